// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the per-operation iteration count.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } state_e;

    // Multiply retires mul_step bits per cycle; restoring divide retires one.
    function automatic int unsigned iter_count(input op_e op, input int unsigned width,
                                               input int unsigned mul_step);
        if (op == OP_DIV || op == OP_DIVU) begin
            return width;
        end
        return width / mul_step;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference only when it does not go negative.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so shifted fits WIDTH+1 bits and diff's MSB is the borrow.
    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with start/busy/done handshake, flush and
// defined divide-by-zero results; drives HI/LO write data.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take operand magnitudes, record result signs, load iteration counter
// CALC  | one multiply chunk or one divide bit per cycle
// DONE  | results registered, done_o pulsing; a new start is accepted here
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = WIDTH + MUL_STEP;

    state_e             state;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd_q;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic               neg_q, rem_neg_q;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [PW-1:0]      mul_sum;
    logic [2*WIDTH+MUL_STEP-1:0] mul_wide;
    logic [2*WIDTH-1:0] mul_next, mul_fix, div_next, step_next;
    logic [WIDTH-1:0]   rem_next, res_hi, res_lo;
    logic               q_bit;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (prod[2*WIDTH-1:WIDTH]),
        .dvd_bit  (prod[WIDTH-1]),
        .divisor  (opnd_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // prod holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        mul_sum   = PW'(prod[2*WIDTH-1:WIDTH]) + PW'(opnd_q) * PW'(prod[MUL_STEP-1:0]);
        mul_wide  = {mul_sum, prod[WIDTH-1:0]} >> MUL_STEP;
        mul_next  = mul_wide[2*WIDTH-1:0];
        mul_fix   = neg_q ? -mul_next : mul_next;
        div_next  = {rem_next, prod[WIDTH-2:0], q_bit};
        step_next = is_div ? div_next : mul_next;
        if (is_div) begin
            res_hi = rem_neg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
            res_lo = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        end else begin
            res_hi = mul_fix[2*WIDTH-1:WIDTH];
            res_lo = mul_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            prod      <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
            dbz_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            state  <= PREP;
                            busy_o <= 1'b1;
                            op_q   <= op_e'(op_i);
                            a_q    <= a_i;
                            b_q    <= b_i;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PREP: begin
                        neg_q     <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        rem_neg_q <= is_signed && a_q[WIDTH-1];
                        opnd_q    <= is_div ? b_abs : a_abs;
                        prod      <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                        cnt       <= CW'(iter_count(op_q, WIDTH, MUL_STEP) - 1);
                        if (is_div && b_q == '0) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            hi_o   <= a_q;
                            lo_o   <= '1;
                            dbz_o  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        prod <= step_next;
                        if (cnt == '0) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            hi_o   <= res_hi;
                            lo_o   <= res_lo;
                            dbz_o  <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: latency, multiply/divide results, divide by zero,
// flush, start handling and asynchronous reset.
module tb_mdu_iter;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic        busy_o, done_o, dbz_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mdu_iter #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .dbz_o   (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start in the current cycle T and leaves the bench in the done cycle T+lat.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        step();
        start_i = 1'b0;
        a_i = 32'h0; b_i = 32'h0;
        repeat (lat - 2) step();
        check({tag, "_busy_before"}, 32'(busy_o), 32'd1);
        check({tag, "_done_early"}, 32'(done_o), 32'd0);
        step();
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_busy_done"}, 32'(busy_o), 32'd0);
        check({tag, "_hi"}, hi_o, ehi);
        check({tag, "_lo"}, lo_o, elo);
        check({tag, "_dbz"}, 32'(dbz_o), 32'(edbz));
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        op_i = 2'b00; a_i = 32'h0; b_i = 32'h0;
        #2;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_dbz", 32'(dbz_o), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        do_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'h0000_0007, 10, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        step();
        check("pulse_one_cycle", 32'(done_o), 32'd0);
        check("hold_lo", lo_o, 32'hFFFF_FFEB);
        do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        step();
        do_op("mult_both_neg", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 10, 32'h0, 32'h0000_001E, 1'b0);
        step();
        do_op("div_neg", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        step();
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
        step();
        do_op("div_negb", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        step();
        do_op("divu", DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        step();
        do_op("divu_dbz", DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);
        step();
        check("dbz_held", 32'(dbz_o), 32'd1);
        do_op("div_dbz_neg", DIV, 32'hFFFF_FFF0, 32'd0, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        step();
        do_op("multu_after_dbz", MULTU, 32'd2, 32'd3, 10, 32'd0, 32'd6, 1'b0);
        step();

        // flush mid-divide: start at T, flush during T+5
        op_i = DIVU; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_done", 32'(done_o), 32'd0);
        check("flush_hi", hi_o, 32'd0);
        check("flush_lo", lo_o, 32'd6);
        do_op("after_flush", MULTU, 32'd9, 32'd11, 10, 32'd0, 32'd99, 1'b0);
        step();

        // flush and start together in IDLE: start dropped
        op_i = MULTU; a_i = 32'd4; b_i = 32'd4; start_i = 1'b1; flush_i = 1'b1;
        step();
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_start_busy", 32'(busy_o), 32'd0);
        repeat (10) step();
        check("flush_start_lo", lo_o, 32'd99);

        // start held high with new operands while busy: ignored, nothing queued
        op_i = MULTU; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
        step();
        op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
        repeat (8) step();
        start_i = 1'b0;
        step();
        check("held_done", 32'(done_o), 32'd1);
        check("held_lo", lo_o, 32'd12);
        check("held_hi", hi_o, 32'd0);
        step();
        check("held_no_queue", 32'(busy_o), 32'd0);

        // back-to-back: second start issued in the first DONE cycle
        do_op("b2b_first", MULTU, 32'd5, 32'd7, 10, 32'd0, 32'd35, 1'b0);
        do_op("b2b_second", MULT, 32'hFFFF_FFFE, 32'd3, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        step();

        // async reset in the middle of CALC
        op_i = DIVU; a_i = 32'd77; b_i = 32'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_hi", hi_o, 32'd0);
        check("arst_lo", lo_o, 32'd0);
        check("arst_dbz", 32'(dbz_o), 32'd0);
        step();
        rst = 1'b1;
        repeat (40) step();
        check("arst_no_done_lo", lo_o, 32'd0);
        do_op("after_arst", DIVU, 32'd77, 32'd5, 34, 32'd2, 32'd15, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit. It is the next generation of the single-result MDU in the EX stage.
- Supports signed and unsigned multiply and divide at configurable width.
- Multiply retires MUL_STEP bits per cycle. Divide uses a 1-bit/cycle restoring algorithm.
- Uses an explicit start/busy/done handshake, a flush input for pipeline cancel, and defined divide-by-zero results. Drives HI/LO write data for the HILO register.

Parameters:
- WIDTH, 32, operand width. Must be even and at least 8.
- MUL_STEP, 4, multiplier bits consumed per CALC cycle. Must divide WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  launch operation. Accepted only when busy_o=0.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with start.
- a_i  in  WIDTH  multiplicand / dividend. Sampled with start.
- b_i  in  WIDTH  multiplier / divisor. Sampled with start.
- flush_i  in  1  abort the in-flight operation
- busy_o  out  1  high in PREP and CALC
- done_o  out  1  one-cycle pulse; result valid
- hi_o  out  WIDTH  product high half / remainder
- lo_o  out  WIDTH  product low half / quotient
- dbz_o  out  1  last completed op was a divide by zero. Valid with done_o and held.

Behaviour:
- Reset (rst=0, async): state IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0, dbz_o=0. All internal registers are cleared. A reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE: waits for start.
  - PREP: computes operand absolute values (signed ops) and records result signs; loads the iteration counter.
  - CALC: N iterations.
  - DONE: applies sign fix-up; registers hi_o/lo_o/dbz_o; pulses done_o.
- Transitions:
  - IDLE --start--> PREP.
  - PREP --> CALC, or PREP --> DONE directly for a divide with b=0.
  - CALC --counter==0--> DONE.
  - DONE --> IDLE, or DONE --start--> PREP.
- Latency: start accepted in cycle T. PREP at T+1, CALC at T+2..T+1+N, done_o=1 in cycle T+N+2.
  - N = WIDTH/MUL_STEP for multiply (32/4 gives done at T+10).
  - N = WIDTH for divide (done at T+34).
- busy_o=0 in IDLE and DONE. A start in the DONE cycle is accepted, giving back-to-back operation. A start while busy_o=1 is ignored and does not queue.
- hi_o/lo_o/dbz_o update only in the DONE cycle and hold until the next DONE.
- Multiply: the 2*WIDTH product is split as hi=[2W-1:W], lo=[W-1:0]. Signed multiply negates the unsigned product when the operand signs differ.
- Divide: restoring algorithm on absolute values.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0. This wraps naturally; no special casing.
- Divide by zero (DIV or DIVU): skips CALC; done at T+2. Result: lo = all ones, hi = a_i unmodified, dbz_o = 1. Any other op sets dbz_o = 0.
- flush_i = 1 in any state: next state is IDLE; no done pulse; hi_o/lo_o/dbz_o unchanged.
  - flush_i and start_i in the same cycle: flush wins and start is dropped.
  - flush_i in DONE: the done pulse already issued still stands.
- Operands and op are registered at start. Later changes to a_i/b_i/op_i do not affect the operation.

Decomposition:
- Package mdu_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state enum IDLE/PREP/CALC/DONE
  - helper function for the iteration count
- Sub-module mdu_div_step (combinational): one restoring step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder and quotient bit. Parametrised by WIDTH.
- The multiply step stays inline: a MUL_STEP-bit partial-product add.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000007 at T -> done_o at T+10, hi=FFFFFFFF, lo=FFFFFFEB. busy_o high T+1..T+9.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=2 -> done at T+34, lo=FFFFFFFD, hi=FFFFFFFF. Also DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=5, b=0 -> done at T+2, lo=FFFFFFFF, hi=00000005, dbz_o=1. A following MULTU 2*3 -> dbz_o=0, lo=6.
- DIVU started at T, flush_i at T+5 -> IDLE at T+6, no done pulse, hi/lo keep their prior values. A start at T+6 runs normally.
- start_i held high with new operands during busy -> ignored. A start in the DONE cycle is accepted: second done at T'+N+2. Async reset mid-CALC -> all outputs 0 immediately.
